// File: rtl/ghash_pkg.sv
// ghash_pkg: shared width, reduction constant and state/type encodings for the GHASH block.
package ghash_pkg;
   localparam int DATA_WIDTH = 128;
   localparam logic [DATA_WIDTH-1:0] GHASH_R = 128'he1000000000000000000000000000000;
   typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_MULT, S_LEN, S_DONE} state_e;
   typedef enum logic {BLK_AAD = 1'b0, BLK_CT = 1'b1} blk_type_e;
endpackage

// File: rtl/gf128_mul.sv
// gf128_mul: combinational GF(2^128) product x*h in GCM bit order (bit 127 = x^0).
module gf128_mul
   import ghash_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] x_i,
   input  logic [DATA_WIDTH-1:0] h_i,
   output logic [DATA_WIDTH-1:0] z_o
);
   logic [DATA_WIDTH-1:0] z, v;
   // Shifting right multiplies by x; the bit leaving at x^127 folds back through R.
   always_comb begin
      z = '0;
      v = h_i;
      for (int i = DATA_WIDTH-1; i >= 0; i--) begin
         z = x_i[i] ? z ^ v : z;
         v = v[0] ? (v >> 1) ^ GHASH_R : v >> 1;
      end
   end
   assign z_o = z;
endmodule

// File: rtl/ghash_ctrl.sv
// ghash_ctrl: sequences gf128_mul to fold a block stream into Y <= (Y ^ X) * H.
// Define GHASH_AUTO_LEN_EN to append the GCM length block built from the block counters.
module ghash_ctrl
   import ghash_pkg::*;
#(
   parameter int MULT_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] h_i,
   input  logic                  h_valid_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] blk_i,
   input  logic                  blk_type_i,
   input  logic                  blk_last_i,
   input  logic                  blk_valid_i,
   output logic                  blk_ready_o,
   output logic [DATA_WIDTH-1:0] tag_o,
   output logic                  tag_valid_o,
   input  logic                  tag_ready_i,
   output logic                  busy_o,
   output logic                  err_o
);
   localparam int WW = $clog2(MULT_LAT + 1);
   localparam logic [WW-1:0] WAIT_INIT = WW'(MULT_LAT - 1);

   state_e                state_q, state_d, fin_state;
   logic [DATA_WIDTH-1:0] h_q, h_d, y_q, y_d, x_q, x_d, prod, len_blk;
   logic [CNT_W-1:0]      aad_cnt_q, aad_cnt_d, ct_cnt_q, ct_cnt_d;
   logic [WW-1:0]         wait_q, wait_d;
   logic                  hl_q, hl_d, err_q, err_d, last_q, last_d, len_q, len_d;
   logic                  h_ok, is_ct, sel_sat;

   gf128_mul u_mul (.x_i(x_q), .h_i(h_q), .z_o(prod));

`ifdef GHASH_AUTO_LEN_EN
   assign fin_state = S_LEN;
   assign len_blk   = {64'(aad_cnt_q) << 7, 64'(ct_cnt_q) << 7};
`else
   assign fin_state = S_DONE;
   assign len_blk   = '0;
`endif

   // A start in the same cycle as h_valid_i uses the H being loaded.
   assign h_ok    = hl_q | h_valid_i;
   assign is_ct   = blk_type_e'(blk_type_i) == BLK_CT;
   assign sel_sat = is_ct ? &ct_cnt_q : &aad_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         h_q       <= '0;
         y_q       <= '0;
         x_q       <= '0;
         aad_cnt_q <= '0;
         ct_cnt_q  <= '0;
         wait_q    <= '0;
         hl_q      <= 1'b0;
         err_q     <= 1'b0;
         last_q    <= 1'b0;
         len_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         y_q       <= y_d;
         x_q       <= x_d;
         aad_cnt_q <= aad_cnt_d;
         ct_cnt_q  <= ct_cnt_d;
         wait_q    <= wait_d;
         hl_q      <= hl_d;
         err_q     <= err_d;
         last_q    <= last_d;
         len_q     <= len_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = (start_i && h_ok) ? S_ACCEPT : S_IDLE;
         S_ACCEPT: state_d = blk_valid_i ? S_MULT : S_ACCEPT;
         S_MULT:   state_d = (wait_q != '0) ? S_MULT : len_q ? S_DONE : last_q ? fin_state : S_ACCEPT;
         S_LEN:    state_d = S_MULT;
         S_DONE:   state_d = tag_ready_i ? S_IDLE : S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      h_d       = h_q;
      hl_d      = hl_q;
      y_d       = y_q;
      x_d       = x_q;
      aad_cnt_d = aad_cnt_q;
      ct_cnt_d  = ct_cnt_q;
      wait_d    = wait_q;
      err_d     = err_q;
      last_d    = last_q;
      len_d     = len_q;
      case (state_q)
         S_IDLE: begin
            if (h_valid_i) begin
               h_d  = h_i;
               hl_d = 1'b1;
            end
            if (start_i && h_ok) begin
               y_d       = '0;
               aad_cnt_d = '0;
               ct_cnt_d  = '0;
               err_d     = 1'b0;
            end else if (start_i) begin
               err_d = 1'b1;
            end
         end
         S_ACCEPT: if (blk_valid_i) begin
            x_d       = y_q ^ blk_i;
            aad_cnt_d = (!is_ct && !sel_sat) ? aad_cnt_q + CNT_W'(1) : aad_cnt_q;
            ct_cnt_d  = (is_ct && !sel_sat) ? ct_cnt_q + CNT_W'(1) : ct_cnt_q;
            err_d     = err_q | sel_sat | (!is_ct && ct_cnt_q != '0);
            last_d    = blk_last_i;
            len_d     = 1'b0;
            wait_d    = WAIT_INIT;
         end
         S_MULT: begin
            wait_d = (wait_q != '0) ? wait_q - WW'(1) : wait_q;
            y_d    = (wait_q == '0) ? prod : y_q;
         end
         S_LEN: begin
            x_d    = y_q ^ len_blk;
            len_d  = 1'b1;
            wait_d = WAIT_INIT;
         end
         default: ;
      endcase
   end

   always_comb begin
      blk_ready_o = state_q == S_ACCEPT;
      tag_valid_o = state_q == S_DONE;
      busy_o      = state_q != S_IDLE;
      tag_o       = y_q;
      err_o       = err_q;
   end
endmodule

// File: tb/tb_ghash_ctrl.sv
// tb_ghash_ctrl: random and known-answer messages scored against a polynomial GHASH model.
module tb_ghash_ctrl;
   localparam int LAT = 1;

   typedef struct packed {
      logic [127:0] tag;
      logic         err;
   } exp_t;

   logic         clk = 1'b0, rst;
   logic [127:0] h_i, blk_i, tag_o;
   logic         h_valid_i, start_i, blk_type_i, blk_last_i, blk_valid_i;
   logic         blk_ready_o, tag_valid_o, tag_ready_i, busy_o, err_o;

   exp_t         sb [$];
   string        cq_n [$];
   logic [127:0] cq_a [$];
   logic [127:0] cq_e [$];
   int           hs_q [$];
   int           n_vec = 0, n_bad = 0, cyc = 0, mn;
   logic [127:0] mb [8];
   logic         mt [8];
   logic [127:0] kat, blk;
   logic         kat_en = 1'b0, fin = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ghash_ctrl #(.MULT_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .h_i(h_i), .h_valid_i(h_valid_i), .start_i(start_i),
      .blk_i(blk_i), .blk_type_i(blk_type_i), .blk_last_i(blk_last_i),
      .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .tag_o(tag_o),
      .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i), .busy_o(busy_o), .err_o(err_o)
   );

   // Carry-less product on natural exponents, then fold x^128 = x^7 + x^2 + x + 1.
   function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
      logic [254:0] p;
      logic [127:0] r;
      p = '0;
      for (int i = 0; i < 128; i++)
         if (a[127-i])
            for (int j = 0; j < 128; j++)
               if (b[127-j]) p[i+j] = ~p[i+j];
      for (int k = 254; k >= 128; k--)
         if (p[k]) begin
            p[k]     = 1'b0;
            p[k-121] = ~p[k-121];
            p[k-126] = ~p[k-126];
            p[k-127] = ~p[k-127];
            p[k-128] = ~p[k-128];
         end
      for (int k = 0; k < 128; k++) r[127-k] = p[k];
      return r;
   endfunction

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      cq_n.push_back(n);
      cq_a.push_back(a);
      cq_e.push_back(e);
   endtask

   task automatic send(input logic [127:0] b, input logic t, input logic l);
      int w;
      w = 0;
      blk_i = b; blk_type_i = t; blk_last_i = l; blk_valid_i = 1'b1;
      while (!blk_ready_o && w < 50) begin
         tick();
         w++;
      end
      chk("blk_ready_wait", 128'(blk_ready_o), 128'd1);
      tick();
      hs_q.push_back(cyc);
      blk_valid_i = 1'b0;
      blk_last_i  = 1'b0;
   endtask

   task automatic run_msg(input logic [127:0] h, input int rdly);
      logic [127:0] y;
      logic         e, sct;
      logic         erun [8];
      int           ac, cc, w;
      y = '0; e = 1'b0; sct = 1'b0; ac = 0; cc = 0;
      for (int i = 0; i < mn; i++) begin
         y = gmul(y ^ mb[i], h);
         if (mt[i]) begin
            sct = 1'b1;
            cc++;
         end else begin
            e = e | sct;
            ac++;
         end
         erun[i] = e;
      end
`ifdef GHASH_AUTO_LEN_EN
      y = gmul(y ^ {64'(ac) << 7, 64'(cc) << 7}, h);
`endif
      sb.push_back({y, e});
      hs_q.delete();
      tag_ready_i = 1'b0;
      h_i = h;
      h_valid_i = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
         tick();
         h_valid_i = 1'b0;
      end
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      h_valid_i = 1'b0;
      chk("start_busy", 128'(busy_o), 128'd1);
      chk("start_err_clr", 128'(err_o), 128'd0);
      tag_ready_i = (rdly == 0);
      for (int i = 0; i < mn; i++) begin
         send(mb[i], mt[i], i == mn - 1);
         chk("err_run", 128'(err_o), 128'(erun[i]));
      end
      w = 0;
      while (!tag_valid_o && w < 100) begin
         tick();
         w++;
      end
      chk("tag_valid_wait", 128'(tag_valid_o), 128'd1);
      if (kat_en) chk("kat_tag", tag_o, kat);
      for (int i = 0; i < rdly; i++) begin
         chk("hold_valid", 128'(tag_valid_o), 128'd1);
         chk("hold_tag", tag_o, y);
         chk("hold_ready", 128'(blk_ready_o), 128'd0);
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
      end
      tag_ready_i = 1'b1;
      tick();
      tag_ready_i = 1'b0;
      chk("idle_after", 128'(busy_o), 128'd0);
      chk("valid_drop", 128'(tag_valid_o), 128'd0);
   endtask

   always @(negedge clk) begin
      while (cq_n.size() > 0) begin
         n_vec++;
         if (cq_a[0] !== cq_e[0]) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", cq_n[0], cq_a[0], cq_e[0]);
         end
         cq_n.delete(0);
         cq_a.delete(0);
         cq_e.delete(0);
      end
      if (tag_valid_o && tag_ready_i) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL tag_unexpected: got %h want none", tag_o);
         end else begin
            if ({tag_o, err_o} !== sb[0]) begin
               n_bad++;
               $display("FAIL tag: got %h err %b want %h err %b", tag_o, err_o, sb[0].tag, sb[0].err);
            end
            sb.delete(0);
         end
      end
      if (fin) begin
         n_vec++;
         if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL tags_missing: got %0d pending want 0", sb.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
         $finish;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      h_i = '0; blk_i = '0; h_valid_i = 1'b0; start_i = 1'b0; blk_type_i = 1'b0;
      blk_last_i = 1'b0; blk_valid_i = 1'b0; tag_ready_i = 1'b0;
      repeat (3) tick();
      chk("rst_tag", tag_o, 128'd0);
      chk("rst_valid", 128'(tag_valid_o), 128'd0);
      chk("rst_ready", 128'(blk_ready_o), 128'd0);
      chk("rst_busy", 128'(busy_o), 128'd0);
      chk("rst_err", 128'(err_o), 128'd0);
      rst = 1'b1;
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("noh_err", 128'(err_o), 128'd1);
      chk("noh_busy", 128'(busy_o), 128'd0);

      // NIST GCM test case 2 GHASH
      mb[0] = 128'h0388dace60b6a392f328c2b971b2fe78; mt[0] = 1'b1;
`ifdef GHASH_AUTO_LEN_EN
      mn = 1;
`else
      mn = 2;
      mb[1] = {64'd0, 64'd128}; mt[1] = 1'b1;
`endif
      kat = 128'hf38cbb1ad69223dcc3457ae5b6b0f885; kat_en = 1'b1;
      run_msg(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 0);

      blk = 128'h0123456789abcdef0123456789abcdef;
      mn = 1; mb[0] = blk; mt[0] = 1'b0;
`ifdef GHASH_AUTO_LEN_EN
      kat = blk ^ {64'd128, 64'd0};
`else
      kat = blk;
`endif
      run_msg(128'h80000000000000000000000000000000, 0);

      mn = 3;
      for (int i = 0; i < 3; i++) begin
         mb[i] = r128();
         mt[i] = 1'(i);
      end
      kat = '0;
      run_msg('0, 0);
      for (int i = 1; i < 3; i++) chk("ready_spacing", 128'(hs_q[i] - hs_q[i-1]), 128'(LAT + 1));
      kat_en = 1'b0;

      mn = 2; mb[0] = r128(); mt[0] = 1'b0; mb[1] = r128(); mt[1] = 1'b1;
      run_msg(r128(), 5);

      mn = 3; mb[0] = r128(); mt[0] = 1'b0; mb[1] = r128(); mt[1] = 1'b1; mb[2] = r128(); mt[2] = 1'b0;
      run_msg(r128(), 1);

      // Abort mid-multiply with err set, then confirm H was forgotten.
      h_i = r128(); h_valid_i = 1'b1; start_i = 1'b1;
      tick();
      h_valid_i = 1'b0; start_i = 1'b0;
      send(r128(), 1'b1, 1'b0);
      send(r128(), 1'b0, 1'b0);
      chk("pre_rst_err", 128'(err_o), 128'd1);
      chk("pre_rst_busy", 128'(busy_o), 128'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort_tag", tag_o, 128'd0);
      chk("abort_valid", 128'(tag_valid_o), 128'd0);
      chk("abort_ready", 128'(blk_ready_o), 128'd0);
      chk("abort_busy", 128'(busy_o), 128'd0);
      chk("abort_err", 128'(err_o), 128'd0);
      tick();
      rst = 1'b1;
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("post_rst_noh_err", 128'(err_o), 128'd1);
      chk("post_rst_noh_busy", 128'(busy_o), 128'd0);

      for (int m = 0; m < 25; m++) begin
         int na;
         mn = $urandom_range(1, 4);
         na = $urandom_range(0, mn);
         for (int i = 0; i < mn; i++) begin
            mb[i] = r128();
            mt[i] = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : (i >= na);
         end
         run_msg(r128(), $urandom_range(0, 3));
      end
      repeat (3) tick();
      fin = 1'b1;
   end
endmodule
